// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480@60 raster constants and derived totals.
`timescale 1ns/1ps
package vga_timing_pkg;
    localparam int CNT_W = 10;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    function automatic int axis_total(int visible, int front, int sync, int back);
        return visible + front + sync + back;
    endfunction

    localparam int DEF_H_TOTAL = axis_total(DEF_H_VISIBLE, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK);
    localparam int DEF_V_TOTAL = axis_total(DEF_V_VISIBLE, DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK);
endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis; counts on advance, wraps at the axis total
// and decodes the visible and sync phases from the live count.
`timescale 1ns/1ps
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int VISIBLE = DEF_H_VISIBLE,
    parameter int FRONT   = DEF_H_FRONT,
    parameter int SYNC    = DEF_H_SYNC,
    parameter int BACK    = DEF_H_BACK
) (
    input  logic             clk_25mhz,
    input  logic             rst,
    input  logic             advance,
    output logic [CNT_W-1:0] count,
    output logic             wrap,
    output logic             visible,
    output logic             sync_phase
);
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(axis_total(VISIBLE, FRONT, SYNC, BACK) - 1);
    localparam logic [CNT_W-1:0] VIS_END = CNT_W'(VISIBLE);
    localparam logic [CNT_W-1:0] SYNC_LO = CNT_W'(VISIBLE + FRONT);
    localparam logic [CNT_W-1:0] SYNC_HI = CNT_W'(VISIBLE + FRONT + SYNC - 1);

    always_ff @(posedge clk_25mhz or posedge rst)
        if (rst)
            count <= '0;
        else if (advance)
            count <= wrap ? '0 : count + 1'b1;

    always_comb begin
        wrap       = advance && count == LAST;
        visible    = count < VIS_END;
        sync_phase = count >= SYNC_LO && count <= SYNC_HI;
    end
endmodule

// File: rtl/vga_sync_640x480.sv
// vga_sync_640x480: raster timing generator; two axis counters feed one output
// register stage so every output for a counter pair appears on the same edge.
`timescale 1ns/1ps
module vga_sync_640x480
    import vga_timing_pkg::*;
#(
    parameter int   H_VISIBLE   = DEF_H_VISIBLE,
    parameter int   H_FRONT     = DEF_H_FRONT,
    parameter int   H_SYNC      = DEF_H_SYNC,
    parameter int   H_BACK      = DEF_H_BACK,
    parameter int   V_VISIBLE   = DEF_V_VISIBLE,
    parameter int   V_FRONT     = DEF_V_FRONT,
    parameter int   V_SYNC      = DEF_V_SYNC,
    parameter int   V_BACK      = DEF_V_BACK,
    parameter logic SYNC_ACTIVE = 1'b0
) (
    input  logic             clk_25mhz,
    input  logic             rst,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic [CNT_W-1:0] pixel_x,
    output logic [CNT_W-1:0] pixel_y,
    output logic             line_start,
    output logic             frame_start
);
    logic [CNT_W-1:0] h_cnt, v_cnt;
    logic h_wrap, h_vis, h_sync, v_vis, v_sync, v_wrap_unused;

    vga_axis_counter #(
        .VISIBLE(H_VISIBLE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK)
    ) u_h (
        .clk_25mhz (clk_25mhz),
        .rst       (rst),
        .advance   (1'b1),
        .count     (h_cnt),
        .wrap      (h_wrap),
        .visible   (h_vis),
        .sync_phase(h_sync)
    );

    // Vertical axis steps once per completed line.
    vga_axis_counter #(
        .VISIBLE(V_VISIBLE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK)
    ) u_v (
        .clk_25mhz (clk_25mhz),
        .rst       (rst),
        .advance   (h_wrap),
        .count     (v_cnt),
        .wrap      (v_wrap_unused),
        .visible   (v_vis),
        .sync_phase(v_sync)
    );

    always_ff @(posedge clk_25mhz or posedge rst)
        if (rst) begin
            hsync       <= ~SYNC_ACTIVE;
            vsync       <= ~SYNC_ACTIVE;
            video_on    <= 1'b0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            hsync       <= h_sync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vsync       <= v_sync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            video_on    <= h_vis && v_vis;
            pixel_x     <= h_cnt;
            pixel_y     <= v_cnt;
            line_start  <= h_cnt == '0;
            frame_start <= h_cnt == '0 && v_cnt == '0;
        end
endmodule

// File: tb/tb_vga_sync_640x480.sv
// tb_vga_sync_640x480: scoreboard bench; dut 0 is the default 640x480 raster,
// duts 1/2 are a 15x9 miniature raster (active-low / active-high syncs) for frame-level checks.
`timescale 1ns/1ps
module tb_vga_sync_640x480;
    typedef struct {
        int id; int k; int x; int y; int hs; int vs; int vo; int ls; int fs;
    } exp_t;

    logic clk_25mhz, rst;
    logic [9:0] px [3];
    logic [9:0] py [3];
    logic hs [3];
    logic vs [3];
    logic vo [3];
    logic ls [3];
    logic fs [3];

    exp_t sb [$];
    int n_tests, n_fail;
    int kb, phase_b;
    int hs_low, vo_cnt, first_hs, last_ls, ls_gap, last_fs, fs_gap, vs1_cnt, vs2_cnt, overflow;

    // Hand-computed expectations: id, k (cycle after release), x, y, hs, vs, vo, ls, fs.
    exp_t dir_tab [16] = '{
        '{0,   0,   0, 0, 1, 1, 1, 1, 1},
        '{0,   1,   1, 0, 1, 1, 1, 0, 0},
        '{0, 639, 639, 0, 1, 1, 1, 0, 0},
        '{0, 640, 640, 0, 1, 1, 0, 0, 0},
        '{0, 655, 655, 0, 1, 1, 0, 0, 0},
        '{0, 656, 656, 0, 0, 1, 0, 0, 0},
        '{0, 751, 751, 0, 0, 1, 0, 0, 0},
        '{0, 752, 752, 0, 1, 1, 0, 0, 0},
        '{0, 799, 799, 0, 1, 1, 0, 0, 0},
        '{0, 800,   0, 1, 1, 1, 1, 1, 0},
        '{1,  10,  10, 0, 0, 1, 0, 0, 0},
        '{1,  75,   0, 5, 1, 0, 0, 1, 0},
        '{1, 134,  14, 8, 1, 1, 0, 0, 0},
        '{1, 135,   0, 0, 1, 1, 1, 1, 1},
        '{2,  10,  10, 0, 1, 0, 0, 0, 0},
        '{2,  75,   0, 5, 0, 1, 0, 1, 0}
    };

    vga_sync_640x480 dut0 (
        .clk_25mhz(clk_25mhz), .rst(rst), .hsync(hs[0]), .vsync(vs[0]), .video_on(vo[0]),
        .pixel_x(px[0]), .pixel_y(py[0]), .line_start(ls[0]), .frame_start(fs[0])
    );
    vga_sync_640x480 #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(2), .SYNC_ACTIVE(1'b0)
    ) dut1 (
        .clk_25mhz(clk_25mhz), .rst(rst), .hsync(hs[1]), .vsync(vs[1]), .video_on(vo[1]),
        .pixel_x(px[1]), .pixel_y(py[1]), .line_start(ls[1]), .frame_start(fs[1])
    );
    vga_sync_640x480 #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(2), .SYNC_ACTIVE(1'b1)
    ) dut2 (
        .clk_25mhz(clk_25mhz), .rst(rst), .hsync(hs[2]), .vsync(vs[2]), .video_on(vo[2]),
        .pixel_x(px[2]), .pixel_y(py[2]), .line_start(ls[2]), .frame_start(fs[2])
    );

    initial clk_25mhz = 1'b0;
    always #20 clk_25mhz = ~clk_25mhz;

    function automatic exp_t model(int id, int k);
        int hv, hf, hw, hb, vv, vf, vw, vb, ht, vt, sa;
        exp_t e;
        if (id == 0) begin
            hv = 640; hf = 16; hw = 96; hb = 48; vv = 480; vf = 10; vw = 2; vb = 33;
        end else begin
            hv = 8; hf = 2; hw = 3; hb = 2; vv = 4; vf = 1; vw = 2; vb = 2;
        end
        sa = (id == 2) ? 1 : 0;
        ht = hv + hf + hw + hb;
        vt = vv + vf + vw + vb;
        e.id = id;
        e.k  = k;
        e.x  = k % ht;
        e.y  = (k / ht) % vt;
        e.hs = (e.x >= hv + hf && e.x < hv + hf + hw) ? sa : 1 - sa;
        e.vs = (e.y >= vv + vf && e.y < vv + vf + vw) ? sa : 1 - sa;
        e.vo = (e.x < hv && e.y < vv) ? 1 : 0;
        e.ls = (e.x == 0) ? 1 : 0;
        e.fs = (e.x == 0 && e.y == 0) ? 1 : 0;
        return e;
    endfunction

    function automatic exp_t reset_exp(int id, int tag);
        exp_t e;
        int sa = (id == 2) ? 1 : 0;
        e = '{id, tag, 0, 0, 1 - sa, 1 - sa, 0, 0, 0};
        return e;
    endfunction

    task automatic compare(input exp_t e);
        int gx, gy, ghs, gvs, gvo, gls, gfs;
        gx = int'(px[e.id]); gy = int'(py[e.id]);
        ghs = int'(hs[e.id]); gvs = int'(vs[e.id]); gvo = int'(vo[e.id]);
        gls = int'(ls[e.id]); gfs = int'(fs[e.id]);
        n_tests++;
        if (gx != e.x || gy != e.y || ghs != e.hs || gvs != e.vs || gvo != e.vo || gls != e.ls || gfs != e.fs) begin
            n_fail++;
            $display("FAIL dut%0d k=%0d: got x=%0d y=%0d hs=%0d vs=%0d vo=%0d ls=%0d fs=%0d, expected x=%0d y=%0d hs=%0d vs=%0d vo=%0d ls=%0d fs=%0d",
                     e.id, e.k, gx, gy, ghs, gvs, gvo, gls, gfs, e.x, e.y, e.hs, e.vs, e.vo, e.ls, e.fs);
        end
    endtask

    task automatic check_int(input string nm, input int got, input int need);
        n_tests++;
        if (got != need) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, need);
        end
    endtask

    task automatic push_reset();
        for (int i = 0; i < 3; i++) sb.push_back(reset_exp(i, -1));
    endtask

    task automatic push_step(input int k, input int use_tab);
        for (int i = 0; i < 3; i++) sb.push_back(model(i, k));
        if (use_tab != 0)
            foreach (dir_tab[i]) if (dir_tab[i].k == k) sb.push_back(dir_tab[i]);
    endtask

    // Monitor: drains the scoreboard one output cycle at a time and gathers period statistics.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_25mhz);
            #1;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                compare(e);
            end
            if (phase_b != 0) begin
                if (kb >= 800 && kb < 1600) begin
                    hs_low += hs[0] ? 0 : 1;
                    vo_cnt += vo[0] ? 1 : 0;
                    if (!hs[0] && first_hs < 0) first_hs = int'(px[0]);
                end
                if (ls[0]) begin
                    if (last_ls >= 0) ls_gap = kb - last_ls;
                    last_ls = kb;
                end
                if (fs[1]) begin
                    if (last_fs >= 0) fs_gap = kb - last_fs;
                    last_fs = kb;
                end
                if (kb >= 135 && kb < 270) begin
                    vs1_cnt += vs[1] ? 0 : 1;
                    vs2_cnt += vs[2] ? 1 : 0;
                end
                if (px[0] >= 800 || py[0] >= 525 || px[1] >= 15 || py[1] >= 9) overflow++;
            end
        end
    end

    initial begin
        n_tests = 0; n_fail = 0; kb = -1; phase_b = 0;
        hs_low = 0; vo_cnt = 0; first_hs = -1; last_ls = -1; ls_gap = -1;
        last_fs = -1; fs_gap = -1; vs1_cnt = 0; vs2_cnt = 0; overflow = 0;
        rst = 1'b1;
        repeat (5) begin
            @(posedge clk_25mhz);
            push_reset();
        end
        @(negedge clk_25mhz);
        rst = 1'b0;
        phase_b = 1;
        // Stop where dut1 shows (5,3) and dut0 shows (70,2), then reset mid-frame.
        for (int k = 0; k <= 1670; k++) begin
            @(posedge clk_25mhz);
            kb = k;
            push_step(k, 1);
        end
        @(negedge clk_25mhz);
        phase_b = 0;
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) compare(reset_exp(i, -2));
        repeat (3) begin
            @(posedge clk_25mhz);
            push_reset();
        end
        @(negedge clk_25mhz);
        rst = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk_25mhz);
            push_step(k, 0);
        end
        @(posedge clk_25mhz);
        #2;
        check_int("hsync_low_cycles_line1", hs_low, 96);
        check_int("hsync_first_x", first_hs, 656);
        check_int("video_on_cycles_line1", vo_cnt, 640);
        check_int("line_start_period", ls_gap, 800);
        check_int("mini_frame_start_period", fs_gap, 135);
        check_int("mini_vsync_low_cycles", vs1_cnt, 30);
        check_int("mini_vsync_high_cycles_active_high", vs2_cnt, 30);
        check_int("counter_overflow", overflow, 0);
        check_int("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/vga_sync_640x480.md
# vga_sync_640x480

Raster timing generator for 640x480 at 60 Hz, clocked by the 25 MHz pixel clock from the clock-divider stage. Produces horizontal/vertical sync, a visible-area flag, current pixel coordinates and frame/line markers for downstream pixel-colour logic and the VGA connector. All outputs are registered; counters free-run after reset.

## Interface
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_ACTIVE, 0, asserted level of hsync/vsync (0 = active-low)

- clk_25mhz  input  1  pixel clock, single clock domain, rising edge
- rst  input  1  reset, asynchronous, active-high
- hsync  output  1  horizontal sync
- vsync  output  1  vertical sync
- video_on  output  1  high while (pixel_x, pixel_y) is in the visible area
- pixel_x  output  10  horizontal counter, 0..H_TOTAL-1
- pixel_y  output  10  vertical counter, 0..V_TOTAL-1
- line_start  output  1  one-cycle pulse when pixel_x == 0
- frame_start  output  1  one-cycle pulse when pixel_x == 0 and pixel_y == 0

## Operation
- H_TOTAL = sum of H_* = 800; V_TOTAL = sum of V_* = 525. Counter width 10 bits; totals must be ≤ 1024.
- Internal h_cnt increments every clock; at H_TOTAL-1 wraps to 0 and v_cnt advances.
- v_cnt advances only on h_cnt wrap; at V_TOTAL-1 (with h wrap) wraps to 0.
- Horizontal phases by h_cnt: VISIBLE [0, H_VISIBLE-1], FRONT, SYNC [H_VISIBLE+H_FRONT, +H_SYNC-1] = [656, 751], BACK. Same scheme vertically: vsync on lines [490, 491].
- hsync = SYNC_ACTIVE in horizontal SYNC phase, else ~SYNC_ACTIVE; vsync likewise on v_cnt only (not gated by h phase).
- video_on = h in VISIBLE and v in VISIBLE.
- pixel_x/pixel_y report raw counters in all phases; consumers gate with video_on.
- No input handshake; no stall; the block never stops counting.

## Timing
- Reset (async assert): h_cnt = v_cnt = 0; outputs: hsync = vsync = ~SYNC_ACTIVE (1), video_on = 0, pixel_x = pixel_y = 0, line_start = frame_start = 0.
- Outputs registered from counter state: all outputs for counter value (h, v) appear one edge after the counters hold (h, v); outputs mutually aligned, same cycle.
- First edge after rst deasserts: outputs reflect (0,0): video_on = 1, line_start = frame_start = 1, syncs inactive.
- Line period exactly 800 clocks; frame period exactly 420 000 clocks.
- hsync asserted exactly 96 consecutive cycles per line; vsync asserted exactly 2 × 800 = 1600 consecutive cycles per frame, asserting with pixel_x = 0 of line 490.
- Wrap boundary (799, 524) → (0, 0) in one edge; frame_start follows (799, 524) output cycle immediately.
- rst asserted mid-frame: counters and outputs return to reset values immediately (asynchronous); restart at (0,0) on the first edge after release; no partial line.

## Structure
- Package vga_timing_pkg: default timing constants, H_TOTAL/V_TOTAL derivations, counter width constant.
- Sub-module vga_axis_counter (parameters VISIBLE/FRONT/SYNC/BACK; inputs clk_25mhz, rst, advance; outputs count, wrap, visible, sync_phase), instantiated once per axis; horizontal advance tied high, vertical advance = horizontal wrap.
- Top level holds the output register stage and pulse decode.

## Test plan
- Reset release: hold rst 5 cycles, release → first output cycle pixel_x=0, pixel_y=0, video_on=1, frame_start=1, hsync=vsync=1.
- Horizontal timing: measure over one line → hsync low for cycles pixel_x 656..751 (96 cycles), video_on high for pixel_x 0..639, line_start period 800.
- Vertical timing: run one full frame → vsync low for pixel_y 490..491 (1600 cycles), video_on low for all pixel_y ≥ 480, frame_start period 420 000.
- Wrap: observe (799, 524) → next output (0, 0) with frame_start=1; pixel_x never reaches 800, pixel_y never 525.
- Mid-frame reset: assert rst at pixel (300, 200) between edges → outputs reset asynchronously before the next edge; after release resume at (0,0).
- SYNC_ACTIVE=1 instance: same windows with hsync/vsync polarity inverted, reset value 0.
